// File: rtl/rs_pkg.sv
// rs_pkg: shared sizing defaults for the age-ordered reservation station.
// The entry record itself is declared inside age_ordered_rs because its
// field widths follow that module's parameters.
package rs_pkg;

  localparam int RS_DEPTH_DEF     = 4;
  localparam int RS_ROB_IDX_W_DEF = 4;
  localparam int RS_DATA_W_DEF    = 16;
  localparam int RS_INSTR_W_DEF   = 16;
  localparam int RS_CDB_PORTS_DEF = 4;

endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: DEPTH x DEPTH relative-age tracker. r_older[i][j] set means
// slot j was written before slot i and both are still live. Columns of dead
// slots are always zero, so a new row can simply copy the live vector.
module rs_age_matrix
  import rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  logic [DEPTH-1:0] r_live;
  logic [DEPTH-1:0] r_older [DEPTH];

  // Track live slots; a new row records every survivor as older, frees clear columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= '0;
      for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else begin
      r_live <= (r_live & ~i_free) | i_alloc;
      for (int i = 0; i < DEPTH; i++) begin
        if (i_alloc[i]) r_older[i] <= r_live & ~i_free;
        else            r_older[i] <= r_older[i] & ~i_free;
      end
    end
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++)
      o_grant[i] = i_req[i] & ~|(r_older[i] & i_req);
  end

endmodule

// File: rtl/age_ordered_rs.sv
// age_ordered_rs: reservation station in front of one functional unit.
// Buffers DEPTH dispatched instructions, snoops CDB_PORTS result buses for
// missing operands and issues the oldest fully-ready entry to the FU.
// Optional build macro RS_PERF_CNT_EN adds saturating stall/issue counters.
module age_ordered_rs
  import rs_pkg::*;
#(
  parameter int DEPTH     = RS_DEPTH_DEF,
  parameter int ROB_IDX_W = RS_ROB_IDX_W_DEF,
  parameter int DATA_W    = RS_DATA_W_DEF,
  parameter int INSTR_W   = RS_INSTR_W_DEF,
  parameter int CDB_PORTS = RS_CDB_PORTS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_flush,
  input  logic                           i_wen,
  input  logic [ROB_IDX_W-1:0]           i_in_rob_idx,
  input  logic [INSTR_W-1:0]             i_in_instr,
  input  logic [ROB_IDX_W-1:0]           i_in_tag1,
  input  logic [ROB_IDX_W-1:0]           i_in_tag2,
  input  logic [DATA_W-1:0]              i_in_val1,
  input  logic [DATA_W-1:0]              i_in_val2,
  input  logic                           i_in_rdy1,
  input  logic                           i_in_rdy2,
  output logic                           o_wr_ready,
  output logic                           o_write_failed,
  output logic [$clog2(DEPTH+1)-1:0]     o_occupancy,
  input  logic                           i_fu_ready,
  output logic                           o_out_valid,
  output logic [ROB_IDX_W-1:0]           o_out_rob_idx,
  output logic [INSTR_W-1:0]             o_out_instr,
  output logic [DATA_W-1:0]              o_out_val1,
  output logic [DATA_W-1:0]              o_out_val2,
  input  logic [CDB_PORTS-1:0]           i_cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_W-1:0] i_cdb_rob_idx,
  input  logic [CDB_PORTS*DATA_W-1:0]    i_cdb_result
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]                    o_perf_stall_cnt,
  output logic [31:0]                    o_perf_issue_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [INSTR_W-1:0]   instr;
    logic [ROB_IDX_W-1:0] tag1;
    logic                 rdy1;
    logic [DATA_W-1:0]    val1;
    logic [ROB_IDX_W-1:0] tag2;
    logic                 rdy2;
    logic [DATA_W-1:0]    val2;
  } rs_entry_t;

  // Returns {hit, value}; the lowest-numbered matching channel wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_IDX_W-1:0]           tag,
    input logic [CDB_PORTS-1:0]           vld,
    input logic [CDB_PORTS*ROB_IDX_W-1:0] tags,
    input logic [CDB_PORTS*DATA_W-1:0]    res
  );
    logic [DATA_W:0] hit;
    hit = '0;
    for (int c = CDB_PORTS - 1; c >= 0; c--)
      if (vld[c] && (tags[c*ROB_IDX_W +: ROB_IDX_W] == tag))
        hit = {1'b1, res[c*DATA_W +: DATA_W]};
    return hit;
  endfunction

  rs_entry_t r_ent [DEPTH];

  logic                 r_out_valid;
  logic [ROB_IDX_W-1:0] r_out_rob_idx;
  logic [INSTR_W-1:0]   r_out_instr;
  logic [DATA_W-1:0]    r_out_val1;
  logic [DATA_W-1:0]    r_out_val2;
  logic                 r_write_failed;

  logic [DEPTH-1:0]     w_valid;
  logic [DEPTH-1:0]     w_req;
  logic [DEPTH-1:0]     w_alloc;
  logic [DEPTH-1:0]     w_mat_alloc;
  logic [DEPTH-1:0]     w_free;
  logic [DEPTH-1:0]     w_grant;
  logic                 w_do_write;
  logic                 w_do_issue;
  logic                 w_stall;
  logic [DATA_W:0]      w_wk1 [DEPTH];
  logic [DATA_W:0]      w_wk2 [DEPTH];
  logic [DATA_W:0]      w_in_snoop1;
  logic [DATA_W:0]      w_in_snoop2;
  logic [ROB_IDX_W-1:0] w_iss_rob_idx;
  logic [INSTR_W-1:0]   w_iss_instr;
  logic [DATA_W-1:0]    w_iss_val1;
  logic [DATA_W-1:0]    w_iss_val2;

  // Slot status, issue candidates and the lowest free slot for the next write.
  always_comb begin
    w_valid = '0;
    w_req   = '0;
    w_alloc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_req[i]   = r_ent[i].valid & r_ent[i].rdy1 & r_ent[i].rdy2;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_alloc    = '0;
        w_alloc[i] = 1'b1;
      end
    end
  end

  // Write/issue qualification; flush overrides both.
  always_comb begin
    o_wr_ready  = ~&w_valid;
    w_stall     = i_wen & ~o_wr_ready;
    w_do_write  = i_wen & o_wr_ready & ~i_flush;
    w_do_issue  = i_fu_ready & (|w_req) & ~i_flush;
    w_mat_alloc = w_do_write ? w_alloc : '0;
    if (i_flush)         w_free = '1;
    else if (w_do_issue) w_free = w_grant;
    else                 w_free = '0;
  end

  // CDB snoop for the dispatch operands and for every stored operand.
  always_comb begin
    w_in_snoop1 = cdb_lookup(i_in_tag1, i_cdb_valid, i_cdb_rob_idx, i_cdb_result);
    w_in_snoop2 = cdb_lookup(i_in_tag2, i_cdb_valid, i_cdb_rob_idx, i_cdb_result);
    for (int i = 0; i < DEPTH; i++) begin
      w_wk1[i] = cdb_lookup(r_ent[i].tag1, i_cdb_valid, i_cdb_rob_idx, i_cdb_result);
      w_wk2[i] = cdb_lookup(r_ent[i].tag2, i_cdb_valid, i_cdb_rob_idx, i_cdb_result);
    end
  end

  // Select the granted entry's payload (grant is one-hot).
  always_comb begin
    w_iss_rob_idx = '0;
    w_iss_instr   = '0;
    w_iss_val1    = '0;
    w_iss_val2    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_iss_rob_idx = r_ent[i].rob_idx;
        w_iss_instr   = r_ent[i].instr;
        w_iss_val1    = r_ent[i].val1;
        w_iss_val2    = r_ent[i].val2;
      end
    end
  end

  // Valid entry count.
  always_comb begin
    o_occupancy = '0;
    for (int i = 0; i < DEPTH; i++)
      o_occupancy = o_occupancy + OCC_W'(w_valid[i]);
  end

  rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_alloc (w_mat_alloc),
    .i_free  (w_free),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  // Entry storage: flush > write into free slot > invalidate on issue > wakeup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_do_write && w_alloc[i]) begin
          r_ent[i].valid   <= 1'b1;
          r_ent[i].rob_idx <= i_in_rob_idx;
          r_ent[i].instr   <= i_in_instr;
          r_ent[i].tag1    <= i_in_tag1;
          r_ent[i].tag2    <= i_in_tag2;
          r_ent[i].rdy1    <= i_in_rdy1 | w_in_snoop1[DATA_W];
          r_ent[i].rdy2    <= i_in_rdy2 | w_in_snoop2[DATA_W];
          r_ent[i].val1    <= i_in_rdy1 ? i_in_val1 : w_in_snoop1[DATA_W-1:0];
          r_ent[i].val2    <= i_in_rdy2 ? i_in_val2 : w_in_snoop2[DATA_W-1:0];
        end else if (w_do_issue && w_grant[i]) begin
          r_ent[i].valid <= 1'b0;
        end else if (r_ent[i].valid) begin
          if (!r_ent[i].rdy1 && w_wk1[i][DATA_W]) begin
            r_ent[i].rdy1 <= 1'b1;
            r_ent[i].val1 <= w_wk1[i][DATA_W-1:0];
          end
          if (!r_ent[i].rdy2 && w_wk2[i][DATA_W]) begin
            r_ent[i].rdy2 <= 1'b1;
            r_ent[i].val2 <= w_wk2[i][DATA_W-1:0];
          end
        end
      end
    end
  end

  // Issue register toward the FU plus the write-failed pulse; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_rob_idx  <= '0;
      r_out_instr    <= '0;
      r_out_val1     <= '0;
      r_out_val2     <= '0;
      r_write_failed <= 1'b0;
    end else begin
      r_out_valid    <= w_do_issue;
      r_write_failed <= w_stall & ~i_flush;
      if (w_do_issue) begin
        r_out_rob_idx <= w_iss_rob_idx;
        r_out_instr   <= w_iss_instr;
        r_out_val1    <= w_iss_val1;
        r_out_val2    <= w_iss_val2;
      end
    end
  end

  assign o_out_valid    = r_out_valid;
  assign o_out_rob_idx  = r_out_rob_idx;
  assign o_out_instr    = r_out_instr;
  assign o_out_val1     = r_out_val1;
  assign o_out_val2     = r_out_val2;
  assign o_write_failed = r_write_failed;

`ifdef RS_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_issue;

  // Saturating event counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_issue <= '0;
    end else begin
      if (w_stall && (r_perf_stall != '1))    r_perf_stall <= r_perf_stall + 32'd1;
      if (w_do_issue && (r_perf_issue != '1)) r_perf_issue <= r_perf_issue + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall;
  assign o_perf_issue_cnt = r_perf_issue;
`endif

endmodule

// File: doc/age_ordered_rs.md
Name: age_ordered_rs

Overview:
Parametrised reservation station for the out-of-order core; sits between rename/dispatch and one functional unit.
Buffers DEPTH instructions and captures operand values from CDB_PORTS common-data-bus channels.
Issues the oldest fully-ready entry when the FU accepts, and frees that slot on issue.
Supports a pipeline flush; generalises the 4-entry, 4-CDB, fixed-width station.

Parameters:
DEPTH, 4, number of entries (>=2)
ROB_IDX_W, 4, width of ROB index / operand tag
DATA_W, 16, operand value width
INSTR_W, 16, raw instruction width
CDB_PORTS, 4, number of CDB broadcast channels

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all entries and any pending issue
wen  in  1  dispatch write request
in_rob_idx  in  ROB_IDX_W  ROB index of dispatched instruction
in_instr  in  INSTR_W  full instruction
in_tag1, in_tag2  in  ROB_IDX_W  producer tag of operand 1/2
in_val1, in_val2  in  DATA_W  operand value when ready
in_rdy1, in_rdy2  in  1  operand already a value
wr_ready  out  1  at least one free entry (combinational from registered state)
write_failed  out  1  registered one-cycle pulse: wen while !wr_ready
occupancy  out  $clog2(DEPTH+1)  valid entry count
fu_ready  in  1  FU can accept an instruction this cycle
out_valid  out  1  issued instruction valid
out_rob_idx  out  ROB_IDX_W  issued ROB index
out_instr  out  INSTR_W  issued instruction
out_val1, out_val2  out  DATA_W  resolved operands
cdb_valid  in  CDB_PORTS  per-channel broadcast valid
cdb_rob_idx  in  CDB_PORTS*ROB_IDX_W  packed broadcast tags, channel 0 in LSBs
cdb_result  in  CDB_PORTS*DATA_W  packed broadcast values

Behaviour:
- Reset: all entries invalid; out_valid=0, write_failed=0, out_* data=0, occupancy=0.
- Write: wen&&wr_ready loads lowest-index free slot; entry becomes youngest in age order.
- Write-time snoop: an operand with in_rdyN=0 whose tag matches a valid CDB channel that same cycle is stored ready with that channel's value.
- wen&&!wr_ready: no state change; write_failed=1 next cycle; otherwise write_failed=0 next cycle.
- Wakeup: each valid, unready operand compares against all channels; on match, value captured and operand ready next cycle; lowest channel index wins if several match.
- Issue candidate: valid entry with both operands ready in registered state; CDB-woken entries are issuable the following cycle.
- Issue: if fu_ready and a candidate exists, the oldest candidate drives out_* registers next cycle with out_valid=1, and its slot is invalidated; otherwise out_valid=0 next cycle. Latency dispatch->issue minimum 2 cycles.
- Slot freed by issue is reusable from the next cycle; wr_ready does not see same-cycle frees.
- Simultaneous write+issue: both happen; occupancy net unchanged.
- Age order: DEPTH x DEPTH age matrix; on write, new row set to "older than me" for all currently valid entries; column cleared on free.
- flush: highest priority; all entries invalid and out_valid=0 next cycle; a simultaneous wen is dropped without write_failed.
- Reset asserted mid-operation: state cleared immediately, regardless of clk.

Optional Feature:
RS_PERF_CNT_EN: when defined, adds outputs perf_stall_cnt[31:0] (cycles with wen&&!wr_ready) and perf_issue_cnt[31:0] (issues); saturating, reset to 0, not cleared by flush.
Undefined: no counters, no ports.

Decomposition:
- Shared package rs_pkg: entry struct (valid, rob_idx, instr, tag/rdy/val x2), CDB channel struct; sizing set via parameters.
- One sub-module rs_age_matrix (DEPTH param): inputs alloc one-hot, free one-hot, request vector; output oldest-grant one-hot.

Test Plan:
- Write entry rob 3, both rdy, vals 0x0011/0x0022, fu_ready=1 -> out_valid 2 cycles later with rob 3, vals 0x0011/0x0022; occupancy back to 0.
- Write rob 1 (tag2=5, unready), then rob 2 (ready), fu_ready=0; CDB ch2 broadcast tag5=0xBEEF; raise fu_ready -> rob 1 issues first (older) with val2=0xBEEF, then rob 2.
- Write with in_tag1=7 unready while CDB ch0 carries tag7=0x1234 same cycle -> entry issues with val1=0x1234, no further broadcast needed.
- Fill DEPTH=4, fu_ready=0, 5th wen -> write_failed pulse one cycle, wr_ready=0, occupancy=4; contents intact.
- With 3 entries, assert flush with wen -> occupancy 0, out_valid 0, no write_failed; rst_n low mid-stream clears outputs asynchronously.
- Two CDB channels (1 and 3) match same tag with 0xAAAA/0xBBBB -> captured value 0xAAAA.
